// File: rtl/literal_fetch_merge_if.sv
// Fetch/decode/issue bundle for literal_fetch_merge: fetch words in, encoder probe, merged out.
// master is the fetch/downstream side; slave is the merge block itself.
interface literal_fetch_merge_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_wfid;
    logic [31:0] in_pc;
    logic        in_is_64;
    logic [63:0] dec_instr;
    logic        dec_literal_required;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_instr;
    logic [31:0] out_literal;
    logic        out_literal_valid;
    logic [5:0]  out_wfid;
    logic [31:0] out_pc;
    logic        seq_error;

    modport master (
        output in_valid, in_data, in_wfid, in_pc, in_is_64, dec_literal_required, out_ready,
        input  in_ready, dec_instr, out_valid, out_instr, out_literal, out_literal_valid,
               out_wfid, out_pc, seq_error
    );

    modport slave (
        input  in_valid, in_data, in_wfid, in_pc, in_is_64, dec_literal_required, out_ready,
        output in_ready, dec_instr, out_valid, out_instr, out_literal, out_literal_valid,
               out_wfid, out_pc, seq_error
    );
endinterface

// File: rtl/literal_fetch_merge.sv
// Merges 32/64-bit instruction dwords and an optional trailing literal into one issue record.
// Optional macro LITERAL_WFID_CHECK_EN rejects continuation dwords from a different wavefront.
module literal_fetch_merge (
    input logic                  clk,
    input logic                  rst,
    literal_fetch_merge_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitHi,
        StCheckLit,
        StWaitLit,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] instr_q, instr_d;
    logic [5:0]  wfid_q, wfid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] lit_q, lit_d;
    logic        lit_flag_q, lit_flag_d;
    logic [6:0]  lit_count_q, lit_count_d;
    logic        in_fire, out_fire, wfid_match;

`ifdef LITERAL_WFID_CHECK_EN
    logic        seq_error_q, seq_error_d;
    assign wfid_match    = (bus.in_wfid == wfid_q);
    assign bus.seq_error = seq_error_q;
`else
    assign wfid_match    = 1'b1;
    assign bus.seq_error = 1'b0;
`endif

    assign bus.in_ready  = (state_q == StIdle) || (state_q == StWaitHi) || (state_q == StWaitLit);
    assign bus.out_valid = (state_q == StHold);
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    // Encoders see only registered state, so there is no loop back through in_data.
    assign bus.dec_instr         = instr_q;
    assign bus.out_instr         = instr_q;
    assign bus.out_literal       = lit_flag_q ? lit_q : 32'h0;
    assign bus.out_literal_valid = lit_flag_q;
    assign bus.out_wfid          = wfid_q;
    assign bus.out_pc            = pc_q;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        wfid_d      = wfid_q;
        pc_d        = pc_q;
        lit_d       = lit_q;
        lit_flag_d  = lit_flag_q;
        lit_count_d = lit_count_q;
`ifdef LITERAL_WFID_CHECK_EN
        seq_error_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_fire) begin
                    instr_d = {32'h0, bus.in_data};
                    wfid_d  = bus.in_wfid;
                    pc_d    = bus.in_pc;
                    state_d = bus.in_is_64 ? StWaitHi : StCheckLit;
                end
            end
            StWaitHi: begin
                if (in_fire) begin
                    if (wfid_match) begin
                        instr_d[63:32] = bus.in_data;
                        state_d        = StCheckLit;
                    end
`ifdef LITERAL_WFID_CHECK_EN
                    else begin
                        seq_error_d = 1'b1;
                        state_d     = StIdle;
                    end
`endif
                end
            end
            StCheckLit: begin
                state_d = bus.dec_literal_required ? StWaitLit : StHold;
            end
            StWaitLit: begin
                if (in_fire) begin
                    if (wfid_match) begin
                        lit_d      = bus.in_data;
                        lit_flag_d = 1'b1;
                        state_d    = StHold;
                    end
`ifdef LITERAL_WFID_CHECK_EN
                    else begin
                        seq_error_d = 1'b1;
                        state_d     = StIdle;
                    end
`endif
                end
            end
            StHold: begin
                if (out_fire) begin
                    if (lit_flag_q) begin
                        lit_count_d = lit_count_q + 7'd1;
                    end
                    lit_flag_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            instr_q     <= 64'h0;
            wfid_q      <= 6'h0;
            pc_q        <= 32'h0;
            lit_q       <= 32'h0;
            lit_flag_q  <= 1'b0;
            lit_count_q <= 7'h0;
`ifdef LITERAL_WFID_CHECK_EN
            seq_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            wfid_q      <= wfid_d;
            pc_q        <= pc_d;
            lit_q       <= lit_d;
            lit_flag_q  <= lit_flag_d;
            lit_count_q <= lit_count_d;
`ifdef LITERAL_WFID_CHECK_EN
            seq_error_q <= seq_error_d;
`endif
        end
    end

endmodule

// File: tb/tb_literal_fetch_merge.sv
// Directed bench for literal_fetch_merge: latency, literal capture, back-pressure, reset, wrap.
module tb_literal_fetch_merge;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   exp_lc;

    literal_fetch_merge_if bus ();

    literal_fetch_merge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one instruction back-to-back; out_valid must appear exactly at the minimum latency.
    task automatic do_instr(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] lit,
                            input logic is64, input logic has_lit, input logic [5:0] wfid,
                            input logic [31:0] pc, input int stall);
        logic [63:0] exp_instr;
        logic [31:0] exp_lit;
        exp_instr = is64 ? {hi, lo} : {32'h0, lo};
        exp_lit   = has_lit ? lit : 32'h0;
        bus.in_valid             = 1'b1;
        bus.in_data              = lo;
        bus.in_wfid              = wfid;
        bus.in_pc                = pc;
        bus.in_is_64             = is64;
        bus.dec_literal_required = has_lit;
        tick();
        if (is64) begin
            check_val("hi_ready", bus.in_ready, 1'b1);
            check_val("hi_early_valid", bus.out_valid, 1'b0);
            bus.in_data  = hi;
            bus.in_is_64 = 1'b0;
            tick();
        end
        bus.in_valid = 1'b0;
        check_val("chk_ready", bus.in_ready, 1'b0);
        check_val("dec_instr", bus.dec_instr, exp_instr);
        check_val("chk_early_valid", bus.out_valid, 1'b0);
        tick();
        if (has_lit) begin
            check_val("lit_ready", bus.in_ready, 1'b1);
            check_val("lit_early_valid", bus.out_valid, 1'b0);
            bus.in_valid = 1'b1;
            bus.in_data  = lit;
            tick();
            bus.in_valid = 1'b0;
        end
        for (int i = 0; i <= stall; i++) begin
            check_val("hold_valid", bus.out_valid, 1'b1);
            check_val("hold_ready", bus.in_ready, 1'b0);
            check_val("out_instr", bus.out_instr, exp_instr);
            check_val("out_literal", bus.out_literal, exp_lit);
            check_val("out_lit_valid", bus.out_literal_valid, has_lit);
            check_val("out_wfid", bus.out_wfid, wfid);
            check_val("out_pc", bus.out_pc, pc);
            if (i < stall) tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        if (has_lit) exp_lc = (exp_lc + 1) % 128;
        check_val("post_valid", bus.out_valid, 1'b0);
        check_val("post_ready", bus.in_ready, 1'b1);
        check_val("post_lit_valid", bus.out_literal_valid, 1'b0);
        check_val("lit_count", dut.lit_count_q, exp_lc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_lc  = 0;
        rst                      = 1'b1;
        bus.in_valid             = 1'b0;
        bus.in_data              = 32'h0;
        bus.in_wfid              = 6'h0;
        bus.in_pc                = 32'h0;
        bus.in_is_64             = 1'b0;
        bus.dec_literal_required = 1'b0;
        bus.out_ready            = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_ready", bus.in_ready, 1'b1);
        check_val("rst_valid", bus.out_valid, 1'b0);
        check_val("rst_instr", bus.out_instr, 64'h0);
        check_val("rst_lit_valid", bus.out_literal_valid, 1'b0);
        check_val("rst_seq_error", bus.seq_error, 1'b0);
        check_val("rst_lit_count", dut.lit_count_q, 0);

        // 32-bit no literal, 32-bit + literal, 64-bit + literal, 64-bit alone
        do_instr(32'h7E000280, 32'h0, 32'h0, 1'b0, 1'b0, 6'd1, 32'h0000_0100, 0);
        do_instr(32'h7E000281, 32'h0, 32'h3F800000, 1'b0, 1'b1, 6'd2, 32'h0000_0104, 0);
        do_instr(32'hD2000000, 32'h000000FF, 32'hDEADBEEF, 1'b1, 1'b1, 6'd7, 32'h0000_0200, 0);
        do_instr(32'hD1000000, 32'h12345678, 32'h0, 1'b1, 1'b0, 6'd9, 32'h0000_0300, 0);
        // Back-pressure for 5 cycles, then the next word goes in immediately
        do_instr(32'hBF810000, 32'h0, 32'h0, 1'b0, 1'b0, 6'd4, 32'h0000_0400, 5);
        do_instr(32'h7E020281, 32'h0, 32'h40490FDB, 1'b0, 1'b1, 6'd4, 32'h0000_0404, 0);

        // Continuation from a different wavefront in WAIT_LIT
        bus.in_valid             = 1'b1;
        bus.in_data              = 32'h02000001;
        bus.in_wfid              = 6'd3;
        bus.in_pc                = 32'h0000_0500;
        bus.in_is_64             = 1'b0;
        bus.dec_literal_required = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check_val("xw_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCAFEF00D;
        bus.in_wfid  = 6'd5;
        tick();
        bus.in_valid = 1'b0;
`ifdef LITERAL_WFID_CHECK_EN
        check_val("xw_seq_error", bus.seq_error, 1'b1);
        check_val("xw_valid", bus.out_valid, 1'b0);
        check_val("xw_idle_ready", bus.in_ready, 1'b1);
        tick();
        check_val("xw_seq_error_pulse", bus.seq_error, 1'b0);
        check_val("xw_valid2", bus.out_valid, 1'b0);
`else
        check_val("xw_seq_error", bus.seq_error, 1'b0);
        check_val("xw_valid", bus.out_valid, 1'b1);
        check_val("xw_literal", bus.out_literal, 32'hCAFEF00D);
        check_val("xw_wfid", bus.out_wfid, 6'd3);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_lc = (exp_lc + 1) % 128;
        check_val("xw_lit_count", dut.lit_count_q, exp_lc);
`endif

        // Reset in WAIT_LIT, colliding with a literal handshake
        bus.in_valid             = 1'b1;
        bus.in_data              = 32'h7E000282;
        bus.in_wfid              = 6'd6;
        bus.in_pc                = 32'h0000_0600;
        bus.dec_literal_required = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check_val("rw_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h11111111;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_lc       = 0;
        check_val("rw_valid", bus.out_valid, 1'b0);
        check_val("rw_instr", bus.out_instr, 64'h0);
        check_val("rw_literal", bus.out_literal, 32'h0);
        check_val("rw_lit_valid", bus.out_literal_valid, 1'b0);
        check_val("rw_wfid", bus.out_wfid, 6'h0);
        check_val("rw_pc", bus.out_pc, 32'h0);
        check_val("rw_ready_after", bus.in_ready, 1'b1);
        check_val("rw_lit_count", dut.lit_count_q, 0);
        tick();
        check_val("rw_valid_later", bus.out_valid, 1'b0);

        // 128 literal instructions: counter wraps back to 0
        for (int k = 0; k < 128; k++) begin
            do_instr(32'h7E000000 + 32'(k), 32'h0, 32'h5000_0000 + 32'(k), 1'b0, 1'b1,
                     6'(k % 64), 32'h1000 + 32'(4 * k), 0);
        end
        check_val("wrap_lit_count", dut.lit_count_q, 7'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
